// File: rtl/grad_pkg.sv
// Shared constants for the Sobel gradient stream: direction codes and
// magnitude-mode encodings.
package grad_pkg;

    // Quantised gradient direction reported alongside each magnitude.
    typedef enum logic [1:0] {
        DIR_H   = 2'b00,
        DIR_45  = 2'b01,
        DIR_V   = 2'b10,
        DIR_135 = 2'b11
    } dir_e;

    // Magnitude approximation selected by cfg_mag_mode.
    localparam logic MAG_SUM    = 1'b0;  // |gx| + |gy|
    localparam logic MAG_MAXMIN = 1'b1;  // max + min/2

    // Row counter only needs to know "row 0", "row 1" or "row 2 and beyond".
    localparam logic [1:0] ROW_FULL = 2'd2;

endpackage

// File: rtl/line_buf.sv
// Single line of pixel storage: one write port, one registered read port.
// Read-before-write when both ports hit the same address in one cycle.
// The enable freezes both the memory and the read register during a stall.
module line_buf #(
    parameter int DEPTH = 1024,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:DEPTH-1];

    // Storage write and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sobel_grad_stream.sv
// Streaming 3x3 Sobel gradient: raster pixels in, one magnitude/direction
// per interior window out.
//
// Handshake: a beat transfers on valid && ready. There is no skid buffer:
// when the output register holds a beat the sink is not taking
// (out_valid && !out_ready) the whole pipeline freezes, and in_ready is the
// inverse of that stall condition.
//
// Pipeline (accept edge = k): s1 line-buffer reads at k, s2 window at k+1,
// s3 gx/gy at k+2, s4 abs/sign at k+3, s5 magnitude terms and direction at
// k+4, output register at k+5.
module sobel_grad_stream
    import grad_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int MAX_W = 1024,
    localparam int LAW  = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LAW-1:0]   cfg_line_len,
    input  logic             cfg_mag_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W+2:0] out_val,
    output logic [1:0]       out_dir
);

    localparam int AIW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int GW  = PIX_W + 3;

    logic stall;
    logic en;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = en;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Position tracking and frame configuration
    // ------------------------------------------------------------------
    logic [LAW-1:0] len_q;
    logic           mode_q;
    logic [LAW-1:0] col_q;
    logic [1:0]     row_q;

    logic [LAW-1:0] pos_col;
    logic [1:0]     pos_row;
    logic [LAW-1:0] eff_len;
    logic           eff_mode;
    logic           last_col;
    logic           pix_qual;

    // Position of the pixel on in_data; a start-of-frame pixel is (0,0) and
    // uses the configuration presented with it.
    always_comb begin
        pos_col  = in_sof ? '0 : col_q;
        pos_row  = in_sof ? '0 : row_q;
        eff_len  = in_sof ? cfg_line_len : len_q;
        eff_mode = in_sof ? cfg_mag_mode : mode_q;
        last_col = (pos_col == eff_len - LAW'(1));
        pix_qual = (pos_row == ROW_FULL) && (pos_col >= LAW'(2));
    end

    // Row/column counters (row saturates at 2) and per-frame config latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= LAW'(MAX_W);
            mode_q <= MAG_SUM;
            col_q  <= '0;
            row_q  <= '0;
        end else if (accept) begin
            if (in_sof) begin
                len_q  <= cfg_line_len;
                mode_q <= cfg_mag_mode;
            end
            if (last_col) begin
                col_q <= '0;
                row_q <= (pos_row == ROW_FULL) ? ROW_FULL : pos_row + 2'd1;
            end else begin
                col_q <= pos_col + LAW'(1);
                row_q <= pos_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds the previous row, lb2 the row before that.
    // lb1 is written with the incoming pixel; lb2 is written one cycle later
    // with the value lb1 returned for the same column.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] lb1_q;
    logic [PIX_W-1:0] lb2_q;

    logic             s1_valid;
    logic             s1_qual;
    logic             s1_mode;
    logic [PIX_W-1:0] s1_pix;
    logic [AIW-1:0]   s1_addr;

    line_buf #(
        .DEPTH (MAX_W),
        .DW    (PIX_W),
        .AW    (AIW)
    ) u_lb1 (
        .clk   (clk),
        .en    (en),
        .we    (accept),
        .waddr (pos_col[AIW-1:0]),
        .wdata (in_data),
        .raddr (pos_col[AIW-1:0]),
        .rdata (lb1_q)
    );

    line_buf #(
        .DEPTH (MAX_W),
        .DW    (PIX_W),
        .AW    (AIW)
    ) u_lb2 (
        .clk   (clk),
        .en    (en),
        .we    (s1_valid),
        .waddr (s1_addr),
        .wdata (lb1_q),
        .raddr (pos_col[AIW-1:0]),
        .rdata (lb2_q)
    );

    // Stage 1: pixel and its bookkeeping, aligned with the buffer reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_qual  <= 1'b0;
            s1_mode  <= MAG_SUM;
            s1_pix   <= '0;
            s1_addr  <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_qual <= pix_qual;
                s1_mode <= eff_mode;
                s1_pix  <= in_data;
                s1_addr <= pos_col[AIW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: 3x3 window, win[row][col]; column 2 is the newest column.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] win [0:2][0:2];
    logic             s2_valid;
    logic             s2_mode;

    // Shift the window one column per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= MAG_SUM;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (en) begin
            s2_valid <= s1_valid && s1_qual;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_q;
                win[1][2] <= lb1_q;
                win[2][2] <= s1_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: signed gradients. PIX_W+3 bits holds +-4*(2^PIX_W-1).
    // ------------------------------------------------------------------
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;
    logic signed [GW-1:0] s3_gx;
    logic signed [GW-1:0] s3_gy;
    logic                 s3_valid;
    logic                 s3_mode;

    // Horizontal gradient is left minus right, vertical is top minus bottom.
    always_comb begin
        gx_c = (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]))
             - (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]));
        gy_c = (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]))
             - (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]));
    end

    // Register the gradients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_mode  <= MAG_SUM;
            s3_gx    <= '0;
            s3_gy    <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_mode <= s2_mode;
                s3_gx   <= gx_c;
                s3_gy   <= gy_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: absolute values and sign agreement.
    // ------------------------------------------------------------------
    logic [GW-1:0] ax_c;
    logic [GW-1:0] ay_c;
    logic          same_c;
    logic [GW-1:0] s4_ax;
    logic [GW-1:0] s4_ay;
    logic          s4_same;
    logic          s4_valid;
    logic          s4_mode;

    // A zero component counts as agreeing with either sign.
    always_comb begin
        ax_c   = s3_gx[GW-1] ? $unsigned(-s3_gx) : $unsigned(s3_gx);
        ay_c   = s3_gy[GW-1] ? $unsigned(-s3_gy) : $unsigned(s3_gy);
        same_c = (s3_gx[GW-1] == s3_gy[GW-1]) || (s3_gx == '0) || (s3_gy == '0);
    end

    // Register magnitudes and sign flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_valid <= 1'b0;
            s4_mode  <= MAG_SUM;
            s4_ax    <= '0;
            s4_ay    <= '0;
            s4_same  <= 1'b0;
        end else if (en) begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_mode <= s3_mode;
                s4_ax   <= ax_c;
                s4_ay   <= ay_c;
                s4_same <= same_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 5: magnitude terms for both modes and direction code.
    // ------------------------------------------------------------------
    logic [GW-1:0] sum_c;
    logic [GW-1:0] mx_c;
    logic [GW-1:0] half_c;
    dir_e          dir_c;
    logic [GW-1:0] s5_sum;
    logic [GW-1:0] s5_mx;
    logic [GW-1:0] s5_half;
    dir_e          s5_dir;
    logic          s5_valid;
    logic          s5_mode;

    // Near-horizontal and near-vertical bands win over the diagonals.
    always_comb begin
        sum_c = s4_ax + s4_ay;
        if (s4_ax >= s4_ay) begin
            mx_c   = s4_ax;
            half_c = s4_ay >> 1;
        end else begin
            mx_c   = s4_ay;
            half_c = s4_ax >> 1;
        end
        if (s4_ax >= (s4_ay << 1)) begin
            dir_c = DIR_H;
        end else if ((s4_ax << 1) <= s4_ay) begin
            dir_c = DIR_V;
        end else if (s4_same) begin
            dir_c = DIR_45;
        end else begin
            dir_c = DIR_135;
        end
    end

    // Register magnitude terms and direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s5_valid <= 1'b0;
            s5_mode  <= MAG_SUM;
            s5_sum   <= '0;
            s5_mx    <= '0;
            s5_half  <= '0;
            s5_dir   <= DIR_H;
        end else if (en) begin
            s5_valid <= s4_valid;
            if (s4_valid) begin
                s5_mode <= s4_mode;
                s5_sum  <= sum_c;
                s5_mx   <= mx_c;
                s5_half <= half_c;
                s5_dir  <= dir_c;
            end
        end
    end

    // Output register: selects the magnitude mode; held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_dir   <= DIR_H;
        end else if (en) begin
            out_valid <= s5_valid;
            if (s5_valid) begin
                out_val <= (s5_mode == MAG_MAXMIN) ? s5_mx + s5_half : s5_sum;
                out_dir <= s5_dir;
            end
        end
    end

endmodule
